// File: rtl/uart_tx_param_if.sv
// Stream handshake bundle feeding the UART transmitter FIFO.
// The producer drives tdata/tvalid; the transmitter returns tready.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_param.sv
// FIFO-buffered UART transmitter: LSB-first serialisation with optional
// parity and one or two stop bits at a fixed clocks-per-bit rate.
// The enable input freezes the serialiser without disturbing FIFO pushes.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 64,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_param_if.slave              s_axis,
    input  logic                        enable,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_WIDTH-1:0]        frame_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = 4;
    localparam logic [PW-1:0] PRESCALE_LOAD = PW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_LEVEL    = (AW+1)'(FIFO_DEPTH);
    localparam logic          PAR_INV       = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          level;
    logic [AW:0]          level_next;
    logic                 tready_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] rd_data;

    // Serialiser state
    state_t               state;
    logic [PW-1:0]        prescale;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 bit_end;
    logic                 stop_last;

    assign s_axis.tready = tready_q;
    assign fifo_level    = level;
    assign push          = s_axis.tvalid && tready_q;
    assign fifo_empty    = (level == '0);
    assign rd_data       = mem[rd_ptr];
    assign bit_end       = (prescale == '0);
    assign stop_last     = (bit_cnt == BCW'(STOP_BITS - 1));
    assign busy          = (state != IDLE) || !fifo_empty;

    // A word leaves the FIFO when idle, or at the end of the final stop bit
    // so that the next frame starts with no idle gap.
    assign pop = enable && !fifo_empty &&
                 ((state == IDLE) || (state == STOP && bit_end && stop_last));

    // Next occupancy; simultaneous push and pop cancel out
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (!push && pop) begin
            level_next = level - 1'b1;
        end
    end

    // FIFO storage write port (contents need no reset; occupancy gates reads)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis.tdata;
        end
    end

    // FIFO pointers, occupancy and registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_next;
            tready_q <= (level_next != FULL_LEVEL);
        end
    end

    // Frame serialiser FSM with registered line output and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prescale    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            txd         <= 1'b1;
            frame_count <= '0;
        end else if (state == IDLE) begin
            txd <= 1'b1;
            if (pop) begin
                shift    <= rd_data;
                par_bit  <= (^rd_data) ^ PAR_INV;
                txd      <= 1'b0;
                prescale <= PRESCALE_LOAD;
                bit_cnt  <= '0;
                state    <= START;
            end
        end else if (enable) begin
            if (!bit_end) begin
                prescale <= prescale - 1'b1;
            end else begin
                prescale <= PRESCALE_LOAD;
                case (state)
                    START: begin
                        state   <= DATA;
                        txd     <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                txd   <= par_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                    PAR: begin
                        state   <= STOP;
                        txd     <= 1'b1;
                        bit_cnt <= '0;
                    end
                    STOP: begin
                        if (stop_last) begin
                            frame_count <= frame_count + 1'b1;
                            bit_cnt     <= '0;
                            if (pop) begin
                                shift   <= rd_data;
                                par_bit <= (^rd_data) ^ PAR_INV;
                                txd     <= 1'b0;
                                state   <= START;
                            end else begin
                                txd   <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        txd   <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
